// File: rtl/mips16_prog_loader.sv
// Purpose: byte-stream program loader filling a 16-bit instruction RAM, holding the CPU in reset meanwhile.
// Latency: RAM word written on the edge accepting its low byte; done pulses the cycle after the last byte.
// Backpressure: byte_ready high in LOAD_HI/LOAD_LO/CHECK; byte_valid=0 stalls indefinitely.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset (also clears RAM)
//   load_req              - starts a session (sampled in IDLE only)
//   byte_valid/byte_data  - program byte stream, high byte of each word first
//   byte_ready            - loader accepts a byte this cycle
//   pc_in / instruction   - combinational fetch port, byte address (bit 0 ignored)
//   cpu_hold              - CPU held in reset while a session is active
//   done                  - one-cycle pulse at session end
//   cksum_err             - sticky result of the last checksum comparison
//
// Build option: define LOADER_CHECKSUM_EN to append a trailing XOR checksum byte
// to each session (CHECK state). Without it a session is NWORDS*2 bytes and
// cksum_err is constant 0.
module mips16_prog_loader #(
    parameter int NWORDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_req,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [15:0] pc_in,
    output logic [15:0] instruction,
    output logic        cpu_hold,
    output logic        done,
    output logic        cksum_err
);

    localparam int AW = $clog2(NWORDS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHECK   = 3'd3,
`endif
        DONE    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   word_cnt_q, word_cnt_d;
    logic [7:0]      hi_q, hi_d;
    logic [15:0]     ram_q [NWORDS];
    logic            ram_we;
    logic            xfer;
    logic            last_word;
    logic [14:0]     widx;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      cksum_q, cksum_d;
    logic            cksum_err_q, cksum_err_d;
`endif

    // Handshake and status outputs decode straight from state, so an
    // asynchronous reset drops them in the same cycle.
    always_comb begin
        byte_ready = 1'b0;
        unique case (state_q)
            LOAD_HI, LOAD_LO: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:            byte_ready = 1'b1;
`endif
            default:          byte_ready = 1'b0;
        endcase
    end

    assign cpu_hold  = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign xfer      = byte_valid & byte_ready;
    assign last_word = (word_cnt_q == AW'(NWORDS - 1));

`ifdef LOADER_CHECKSUM_EN
    assign cksum_err = cksum_err_q;
`else
    assign cksum_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        hi_d       = hi_q;
        ram_we     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        cksum_d     = cksum_q;
        cksum_err_d = cksum_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // cksum_err is deliberately kept across session start.
                if (load_req) begin
                    state_d    = LOAD_HI;
                    word_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    cksum_d    = 8'h00;
`endif
                end
            end
            LOAD_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    state_d = LOAD_LO;
`ifdef LOADER_CHECKSUM_EN
                    cksum_d = cksum_q ^ byte_data;
`endif
                end
            end
            LOAD_LO: begin
                if (xfer) begin
                    ram_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    cksum_d = cksum_q ^ byte_data;
`endif
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = LOAD_HI;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                // Words already written stay in RAM whatever the outcome.
                if (xfer) begin
                    cksum_err_d = (byte_data != cksum_q);
                    state_d     = DONE;
                end
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            hi_q       <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
            cksum_q     <= 8'h00;
            cksum_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            hi_q       <= hi_d;
`ifdef LOADER_CHECKSUM_EN
            cksum_q     <= cksum_d;
            cksum_err_q <= cksum_err_d;
`endif
        end
    end

    // Program RAM: whole array clears on reset so fetches read zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                ram_q[i] <= 16'h0000;
            end
        end else if (ram_we) begin
            ram_q[word_cnt_q] <= {hi_q, byte_data};
        end
    end

    // Fetch by word index; addresses beyond the RAM read as zero.
    assign widx = pc_in[15:1];

    always_comb begin
        instruction = 16'h0000;
        if (widx < 15'(NWORDS)) begin
            instruction = ram_q[widx[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_mips16_prog_loader.sv
module tb_mips16_prog_loader;

    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] instruction;
    logic        cpu_hold;
    logic        done;
    logic        cksum_err;

    int nvec  = 0;
    int nfail = 0;

    mips16_prog_loader #(.NWORDS(NW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_req    (load_req),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .pc_in       (pc_in),
        .instruction (instruction),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .cksum_err   (cksum_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] words [NW];
    logic [15:0] pattern [NW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Applies each fetch vector and compares the combinational instruction.
    task automatic run_vecs(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            pc_in = vecs[i].pc;
            #1;
            check($sformatf("%s pc=%0d", name, vecs[i].pc), {16'h0, instruction},
                  {16'h0, vecs[i].exp_instr});
        end
    endtask

    // Drives one byte and waits (bounded) for the edge that accepts it.
    // Returns 1 ns after that edge with byte_valid dropped.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!byte_ready) begin
            check("byte_ready timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic start_session();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        check("session start byte_ready", {31'd0, byte_ready}, 32'd1);
        check("session start cpu_hold", {31'd0, cpu_hold}, 32'd1);
    endtask

    // After the final transfer: done high now, low next cycle, loader idle.
    task automatic check_end(input string name);
        check({name, " done pulse"}, {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        check({name, " done single"}, {31'd0, done}, 32'd0);
        check({name, " byte_ready idle"}, {31'd0, byte_ready}, 32'd0);
        check({name, " cpu_hold idle"}, {31'd0, cpu_hold}, 32'd0);
    endtask

    // Full session of the words[] contents; stall inserts random idle gaps.
    task automatic load_words(input bit stall, input bit poke_load_req);
        logic [7:0] x = 8'h00;
        start_session();
        for (int w = 0; w < NW; w++) begin
            for (int h = 0; h < 2; h++) begin
                logic [7:0] b;
                b = (h == 0) ? words[w][15:8] : words[w][7:0];
                x = x ^ b;
                if (stall) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                if (poke_load_req && w == 3 && h == 0) begin
                    load_req = 1'b1;
                    @(posedge clk); #1;
                    load_req = 1'b0;
                end
                send_byte(b);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic fill_word_vecs();
        vecs.delete();
        for (int i = 0; i < NW; i++) begin
            vecs.push_back('{pc: 16'(2 * i), exp_instr: words[i]});
        end
    endtask

    initial begin
        pattern = '{16'hA55A, 16'h1234, 16'hFFFF, 16'h0001, 16'h8000, 16'hBEEF, 16'h00FF, 16'hFF00,
                    16'h5A5A, 16'hC3C3, 16'h7E7E, 16'h1001, 16'hDEAD, 16'h2468, 16'h1357, 16'hF0F0};

        // Reset state and cleared RAM.
        #12;
        check("reset cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("reset byte_ready", {31'd0, byte_ready}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset cksum_err", {31'd0, cksum_err}, 32'd0);
        vecs.delete();
        for (int i = 0; i < NW; i++) vecs.push_back('{pc: 16'(2 * i), exp_instr: 16'h0000});
        run_vecs("reset ram");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle byte_ready", {31'd0, byte_ready}, 32'd0);

        // 0x01,0x23 then zeros (checksum 0x22 in checksum builds).
        for (int i = 0; i < NW; i++) words[i] = 16'h0000;
        words[0] = 16'h0123;
        load_words(1'b0, 1'b0);
        check_end("basic");
        check("basic cksum_err", {31'd0, cksum_err}, 32'd0);
        vecs.delete();
        vecs.push_back('{pc: 16'd0,  exp_instr: 16'h0123});
        vecs.push_back('{pc: 16'd1,  exp_instr: 16'h0123});
        vecs.push_back('{pc: 16'd2,  exp_instr: 16'h0000});
        vecs.push_back('{pc: 16'd31, exp_instr: 16'h0000});
        vecs.push_back('{pc: 16'd32, exp_instr: 16'h0000});
        vecs.push_back('{pc: 16'hFFFF, exp_instr: 16'h0000});
        run_vecs("basic");

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: error flagged, written words retained.
        start_session();
        send_byte(8'h01);
        send_byte(8'h23);
        for (int i = 0; i < 2 * NW - 2; i++) send_byte(8'h00);
        send_byte(8'h23);
        check_end("badck");
        check("badck cksum_err", {31'd0, cksum_err}, 32'd1);
        pc_in = 16'd0; #1;
        check("badck ram0 kept", {16'h0, instruction}, 32'h0123);
        // Error flag persists through the start of the next session.
        start_session();
        check("badck err sticky", {31'd0, cksum_err}, 32'd1);
        for (int i = 0; i < 2 * NW; i++) send_byte(8'h00);
        send_byte(8'h00);
        check_end("goodck");
        check("goodck cksum_err", {31'd0, cksum_err}, 32'd0);
`endif

        // Stalled load with a stray load_req mid-session.
        for (int i = 0; i < NW; i++) words[i] = pattern[i];
        load_words(1'b1, 1'b1);
        check_end("stall");
        check("stall cksum_err", {31'd0, cksum_err}, 32'd0);
        fill_word_vecs();
        run_vecs("stall");

        // Reset after 7 accepted bytes takes effect immediately.
        start_session();
        for (int i = 0; i < 7; i++) send_byte(8'h11 * 8'(i + 1));
        rst_n = 1'b0;
        #1;
        check("midrst cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("midrst byte_ready", {31'd0, byte_ready}, 32'd0);
        pc_in = 16'd0; #1;
        check("midrst ram cleared", {16'h0, instruction}, 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst idle", {31'd0, cpu_hold}, 32'd0);

        // Fresh full session after reset.
        for (int i = 0; i < NW; i++) words[i] = pattern[NW - 1 - i];
        load_words(1'b0, 1'b0);
        check_end("fresh");
        fill_word_vecs();
        run_vecs("fresh");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mips16_prog_loader.md
MIPS16_PROG_LOADER -- requirements
Module: mips16_prog_loader

Interface
REQ-001 SHALL have parameter NWORDS, default 16, number of 16-bit instruction words in the program RAM; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load_req, input, 1 bit: start a load session; sampled only in IDLE.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_data holds a valid program byte.
REQ-006 SHALL have port byte_data, input, 8 bits: program byte stream, high byte of each word first.
REQ-007 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 SHALL have port pc_in, input, 16 bits: CPU byte address used for instruction fetch.
REQ-009 SHALL have port instruction, output, 16 bits: fetched instruction word.
REQ-010 SHALL have port cpu_hold, output, 1 bit: CPU must be held in reset while this is high.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at session end.
REQ-012 SHALL have port cksum_err, output, 1 bit: last session failed its checksum.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_HI, LOAD_LO, CHECK and DONE.
REQ-014 IDLE SHALL go to LOAD_HI when load_req=1, clearing the word counter and the running checksum; load_req SHALL be ignored in all other states.
REQ-015 A byte transfer SHALL occur only on a cycle where byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 exactly in LOAD_HI, LOAD_LO and CHECK.
REQ-016 LOAD_HI transfer SHALL latch byte_data as the high byte and go to LOAD_LO.
REQ-017 LOAD_LO transfer SHALL write {hi, byte_data} into ram[word_cnt] on the same edge.
- Then, if word_cnt = NWORDS-1: go to CHECK when LOADER_CHECKSUM_EN is defined, otherwise go to DONE.
- Else: increment word_cnt and go to LOAD_HI.
REQ-018 The running checksum SHALL be the 8-bit XOR of every accepted program byte.
REQ-019 CHECK transfer SHALL set cksum_err to (byte_data != running checksum) and go to DONE.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-021 The done pulse SHALL occur the cycle after the final byte transfer.
REQ-022 cpu_hold SHALL be 1 in every state except IDLE.
REQ-023 instruction SHALL be combinational: ram[pc_in>>1] when (pc_in>>1) < NWORDS, else 16'h0000; pc_in bit 0 SHALL be ignored.
REQ-024 byte_valid=0 SHALL stall the FSM indefinitely with no timeout.
REQ-025 RAM words already written SHALL keep their new values when a checksum error occurs; no rollback.
REQ-026 cksum_err SHALL hold its value until the next CHECK transfer or reset; it SHALL NOT be cleared at session start.

Reset
REQ-027 rst_n=0 SHALL immediately force the following, regardless of state (including mid-session): state=IDLE, word_cnt=0, checksum=0, hi byte=0, byte_ready=0, cpu_hold=0, done=0, cksum_err=0.
REQ-028 rst_n=0 SHALL clear all RAM words to 16'h0000, so instruction reads 16'h0000 after reset.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: the CHECK state and the checksum byte SHALL be present; a session is NWORDS*2+1 bytes.
REQ-030 Macro LOADER_CHECKSUM_EN undefined: the CHECK state and checksum logic SHALL be absent; a session is NWORDS*2 bytes; cksum_err SHALL be tied to 0.

Verification
REQ-031 Reset, then pc_in=0..30 step 2 -> instruction=16'h0000 at every address; cpu_hold=0; byte_ready=0.
REQ-032 EN defined, NWORDS=16: load bytes 0x01,0x23, then 30 bytes 0x00, then checksum 0x22 -> done pulses once; cksum_err=0; pc_in=0 gives 16'h0123; pc_in=1 gives 16'h0123; pc_in=32 gives 16'h0000.
REQ-033 Same as REQ-032 but checksum byte 0x23 -> cksum_err=1 and ram[0]=16'h0123 retained.
REQ-034 byte_valid toggled randomly 50% during a load -> same RAM contents as an unstalled load; byte_ready=0 in IDLE; load_req pulsed mid-session has no effect.
REQ-035 rst_n=0 after 7 accepted bytes -> IDLE same cycle; cpu_hold=0; a fresh full session then loads correctly.
REQ-036 EN undefined: 32 bytes -> done on the cycle after the 32nd byte; cksum_err=0; byte_ready=0 afterwards.
